// File: rtl/lab9_btn_pkg.sv
// Shared register map and debounce state encoding for the button event controller.
package lab9_btn_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } db_state_t;

endpackage

// File: rtl/lab9_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter FSM and press strobe.
module lab9_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic stable,
    output logic press_pulse
);
    import lab9_btn_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // Combinational so the capture bit sets on the same edge that updates stable.
    assign settle      = (state == CHANGING) && (sync2 != stable) && (cnt == CNT_LAST);
    assign press_pulse = settle && stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= STABLE;
            cnt    <= '0;
            stable <= 1'b1;
        end else begin
            case (state)
                STABLE: begin
                    if (sync2 != stable) begin
                        state <= CHANGING;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                CHANGING: begin
                    if (sync2 == stable) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        stable <= sync2;
                        state  <= STABLE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lab9_button_event_ctrl.sv
// Avalon-MM button controller: debounced levels, press capture and maskable level irq.
module lab9_button_event_ctrl #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    import lab9_btn_pkg::*;

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_btn
        lab9_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk        (clk),
            .reset_n    (reset_n),
            .pin        (in_port[i]),
            .stable     (stable[i]),
            .press_pulse(press[i])
        );
    end

    // Reads are side-effect free, so the strobe and upper write bits carry no information.
    assign unused_bits = ^{read, writedata[31:WIDTH]};

    assign wr_en = chipselect && write;
    assign clr   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = ~stable;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_RSVD:    rd_next            = '0;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_capture;
            default:      rd_next            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // Set has priority over a same-cycle write-1-to-clear.
            edge_capture <= (edge_capture & ~clr) | press;
            readdata     <= rd_next;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_lab9_button_event_ctrl.sv
// Directed bench for lab9_button_event_ctrl with DEBOUNCE_CYCLES = 4.
module tb_lab9_button_event_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int unsigned checks;
    int unsigned failures;
    logic [31:0] rd;

    lab9_button_event_ctrl #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        address    = 2'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        in_port    = 4'b0000;

        // 1. Reset state, then all keys held low through release
        repeat (2) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("data_before_settle", readdata, 32'h0);
        @(negedge clk);
        check("data_after_settle", readdata, 32'hF);
        in_port = 4'b1111;
        repeat (8) @(negedge clk);
        bus_write(2'd3, 32'hF);
        bus_read(2'd3, rd);
        check("edgecap_cleared", rd, 32'h0);

        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(2'd3, rd);
        check("edgecap_no_reset_event", rd, 32'h0);
        bus_read(2'd0, rd);
        check("data_released", rd, 32'h0);

        // 2. Clean press of KEY2
        in_port = 4'b1011;
        repeat (6) @(negedge clk);
        check("key2_data_early", readdata, 32'h0);
        @(negedge clk);
        check("key2_data", readdata, 32'h4);
        bus_read(2'd3, rd);
        check("key2_edgecap", rd, 32'h4);
        check("key2_irq_masked", {31'b0, irq}, 32'h0);

        // 3. Glitch of 3 cycles rejected, 4 cycles accepted
        in_port = 4'b1010;
        repeat (3) @(negedge clk);
        in_port = 4'b1011;
        repeat (8) @(negedge clk);
        check("glitch_data", readdata, 32'h4);
        bus_read(2'd3, rd);
        check("glitch_edgecap", rd, 32'h4);
        in_port = 4'b1010;
        repeat (4) @(negedge clk);
        in_port = 4'b1011;
        repeat (12) @(negedge clk);
        bus_read(2'd3, rd);
        check("min_press_edgecap", rd, 32'h5);
        bus_read(2'd0, rd);
        check("min_press_data", rd, 32'h4);

        // 4. Interrupt flow on KEY1
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, rd);
        check("irqmask_rb", rd, 32'h2);
        check("irq_idle", {31'b0, irq}, 32'h0);
        in_port = 4'b1001;
        repeat (6) @(negedge clk);
        check("irq_before_capture", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_asserted", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h2);
        check("irq_lag_after_clear", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        repeat (20) @(negedge clk);
        check("irq_held_key", {31'b0, irq}, 32'h0);
        bus_read(2'd3, rd);
        check("held_key_edgecap", rd, 32'h5);

        // 5. KEY3 press completes on the same edge as a clear of bit 3
        in_port = 4'b0001;
        repeat (5) @(negedge clk);
        bus_write(2'd3, 32'h8);
        bus_read(2'd3, rd);
        check("collision_edgecap", rd, 32'hD);
        check("collision_irq", {31'b0, irq}, 32'h0);

        // 6. Read-only and reserved addresses ignore writes
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd0, rd);
        check("data_unchanged", rd, 32'hE);
        bus_read(2'd2, rd);
        check("rsvd_zero", rd, 32'h0);
        bus_read(2'd1, rd);
        check("irqmask_kept", rd, 32'h2);
        bus_read(2'd3, rd);
        check("edgecap_kept", rd, 32'hD);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, rd);
        check("irqmask_upper_zero", rd, 32'hF);
        check("irq_full_mask", {31'b0, irq}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
